// File: rtl/adder_accumulator.sv
// Registered accumulator around a gate-level 4-bit ripple adder: operands arrive over
// valid/ready, the adder is given SETTLE_CYCLES to resolve, then sum and flags are captured.

module FullAdder4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o,
    output logic       ovf_o
);
    logic [4:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[4];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf_o  = c[4] ^ c[3];
endmodule

module adder_accumulator #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned COUNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_operand,
    output logic [3:0]             acc,
    output logic                   acc_carry,
    output logic                   acc_overflow,
    output logic                   sticky_overflow,
    output logic                   out_valid,
    output logic [COUNT_WIDTH-1:0] op_count
);
    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_SETTLE
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             b_q, b_d;
    logic [3:0]             acc_q, acc_d;
    logic                   carry_q, carry_d;
    logic                   ovf_q, ovf_d;
    logic                   sticky_q, sticky_d;
    logic                   ovalid_q, ovalid_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic [3:0]             add_sum;
    logic                   add_cout;
    logic                   add_ovf;

    FullAdder4bit u_adder (
        .a_i    (acc_q),
        .b_i    (b_q),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout),
        .ovf_o  (add_ovf)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        ovalid_d = 1'b0;
        count_d  = count_q;
        in_ready = 1'b0;

        if (clear) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            acc_d    = '0;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            sticky_d = 1'b0;
            count_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    in_ready = !reset;
                    if (in_valid) begin
                        b_d     = in_operand;
                        cnt_d   = SETTLE_LOAD;
                        state_d = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        acc_d    = add_sum;
                        carry_d  = add_cout;
                        ovf_d    = add_ovf;
                        sticky_d = sticky_q | add_ovf;
                        ovalid_d = 1'b1;
                        if (count_q != '1) begin
                            count_d = count_q + COUNT_WIDTH'(1);
                        end
                        state_d  = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            ovalid_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            ovalid_q <= ovalid_d;
            count_q  <= count_d;
        end
    end

    assign acc             = acc_q;
    assign acc_carry       = carry_q;
    assign acc_overflow    = ovf_q;
    assign sticky_overflow = sticky_q;
    assign out_valid       = ovalid_q;
    assign op_count        = count_q;
endmodule

// File: tb/tb_adder_accumulator.sv
// Bench for adder_accumulator: directed operand sequences checked every cycle against an
// arithmetic model of the accumulator, plus hand-computed expectations.

module tb_adder_accumulator;
    localparam int SETTLE = 4;
    localparam int MAXC   = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_operand = 4'b0000;
    logic       in_ready;
    logic [3:0] acc;
    logic       acc_carry, acc_overflow, sticky_overflow, out_valid;
    logic [7:0] op_count;

    logic       clear2 = 1'b0;
    logic       v2 = 1'b0;
    logic [3:0] op2 = 4'b0000;
    logic       ready2;
    logic [3:0] acc2;
    logic       c2, ovf2, st2, ov2;
    logic [1:0] cnt2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_accumulator #(.SETTLE_CYCLES(SETTLE), .COUNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_operand(in_operand), .acc(acc), .acc_carry(acc_carry), .acc_overflow(acc_overflow),
        .sticky_overflow(sticky_overflow), .out_valid(out_valid), .op_count(op_count)
    );

    adder_accumulator #(.SETTLE_CYCLES(SETTLE), .COUNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear2), .in_valid(v2), .in_ready(ready2),
        .in_operand(op2), .acc(acc2), .acc_carry(c2), .acc_overflow(ovf2),
        .sticky_overflow(st2), .out_valid(ov2), .op_count(cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Returns {sum[3:0], carry, overflow} from plain integer arithmetic.
    function automatic logic [5:0] model_add(input logic [3:0] a, input logic [3:0] b);
        int us, sa, sb, ss;
        logic [3:0] s4;
        us = int'(a) + int'(b);
        sa = (a > 7) ? int'(a) - 16 : int'(a);
        sb = (b > 7) ? int'(b) - 16 : int'(b);
        ss = sa + sb;
        s4 = 4'(us);
        return {s4, (us > 15), (ss > 7 || ss < -8)};
    endfunction

    // Model: remaining cycles until capture (0 = idle) and the architectural outputs.
    int         m_busy = 0;
    logic [3:0] m_b = 4'b0000;
    logic [3:0] m_acc = 4'b0000;
    logic       m_c = 1'b0, m_v = 1'b0, m_st = 1'b0, m_ov = 1'b0;
    int         m_cnt = 0;
    logic [5:0] m_res;

    assign m_res = model_add(m_acc, m_b);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_b <= 4'b0000; m_acc <= 4'b0000;
            m_c <= 1'b0; m_v <= 1'b0; m_st <= 1'b0; m_ov <= 1'b0; m_cnt <= 0;
        end else begin
            m_ov <= 1'b0;
            if (clear) begin
                m_busy <= 0; m_acc <= 4'b0000;
                m_c <= 1'b0; m_v <= 1'b0; m_st <= 1'b0; m_cnt <= 0;
            end else if (m_busy > 1) begin
                m_busy <= m_busy - 1;
            end else if (m_busy == 1) begin
                m_busy <= 0;
                m_acc  <= m_res[5:2];
                m_c    <= m_res[1];
                m_v    <= m_res[0];
                m_st   <= m_st | m_res[0];
                m_ov   <= 1'b1;
                m_cnt  <= (m_cnt >= MAXC) ? MAXC : m_cnt + 1;
            end else if (in_valid) begin
                m_b    <= in_operand;
                m_busy <= SETTLE;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("acc", acc, m_acc);
            chk("carry", acc_carry, m_c);
            chk("overflow", acc_overflow, m_v);
            chk("sticky", sticky_overflow, m_st);
            chk("out_valid", out_valid, m_ov);
            chk("op_count", op_count, m_cnt);
            chk("in_ready", in_ready, (!reset && m_busy == 0 && !clear));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [3:0] op);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_operand = op;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) fail("send_ready");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) fail("wait_out_valid");
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    int exp6[5] = '{1, 2, 3, 3, 3};

    initial begin
        chk("pin 5+3", model_add(4'b0101, 4'b0011), 6'b1000_0_1);
        chk("pin f+1", model_add(4'b1111, 4'b0001), 6'b0000_1_0);
        chk("pin 8+8", model_add(4'b1000, 4'b1000), 6'b0000_1_1);

        @(negedge clk);
        #1;
        chk("rst acc", acc, 0);
        chk("rst flags", {acc_carry, acc_overflow, sticky_overflow, out_valid}, 0);
        chk("rst count", op_count, 0);
        chk("rst ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;

        // 0101 then 0011
        send(4'b0101); wait_done();
        chk("t1 acc0", acc, 4'b0101);
        send(4'b0011); wait_done();
        chk("t1 acc1", acc, 4'b1000);
        chk("t1 c/v/st", {acc_carry, acc_overflow, sticky_overflow}, 3'b011);
        chk("t1 count", op_count, 2);

        // 1111 then 0001 from zero
        do_clear();
        send(4'b1111); wait_done();
        chk("t3 acc0", {acc, acc_carry, acc_overflow}, 6'b1111_0_0);
        send(4'b0001); wait_done();
        chk("t3 acc1", {acc, acc_carry, acc_overflow}, 6'b0000_1_0);
        chk("t3 sticky", sticky_overflow, 0);

        // Latency and single acceptance with in_valid held
        do_clear();
        @(negedge clk);
        in_valid = 1'b1;
        in_operand = 4'b0010;
        #1 chk("t2 ready0", in_ready, 1);
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t2 busy ready", in_ready, 0);
            chk("t2 busy ovalid", out_valid, 0);
        end
        @(negedge clk);
        chk("t2 ovalid", out_valid, 1);
        chk("t2 ready back", in_ready, 1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2 ovalid pulse", out_valid, 0);
        repeat (6) @(negedge clk);
        chk("t2 count", op_count, 1);
        chk("t2 acc", acc, 4'b0010);

        // clear mid-SETTLE with in_valid high
        send(4'b0001);
        @(negedge clk);
        clear = 1'b1;
        in_valid = 1'b1;
        in_operand = 4'b0011;
        #1 chk("t4 ready in clear", in_ready, 0);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("t4 acc", acc, 0);
        chk("t4 sticky/ovalid", {sticky_overflow, out_valid}, 0);
        chk("t4 count", op_count, 0);
        chk("t4 ready", in_ready, 1);
        @(negedge clk);
        chk("t4 accepted", in_ready, 0);
        in_valid = 1'b0;
        wait_done();
        chk("t4 acc after", acc, 4'b0011);
        chk("t4 count after", op_count, 1);

        // async reset mid-SETTLE
        do_clear();
        send(4'b1000); wait_done();
        chk("t5 acc pre", acc, 4'b1000);
        send(4'b0101);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5 async acc", acc, 0);
        chk("t5 async flags", {acc_carry, acc_overflow, sticky_overflow, out_valid}, 0);
        chk("t5 async count", op_count, 0);
        chk("t5 async ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        send(4'b1000); wait_done();
        chk("t5 acc0", acc, 4'b1000);
        send(4'b1000); wait_done();
        chk("t5 acc1", {acc, acc_carry, acc_overflow}, 6'b0000_1_1);

        // 2-bit saturating counter
        for (int i = 0; i < 5; i++) begin
            int t;
            t = 0;
            @(negedge clk);
            v2 = 1'b1;
            while (!ready2 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!ready2) fail("t6 ready");
            @(posedge clk);
            @(negedge clk);
            v2 = 1'b0;
            t = 0;
            while (!ov2 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!ov2) fail("t6 out_valid");
            chk("t6 count", cnt2, exp6[i]);
            chk("t6 acc", acc2, 0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
